dma_io_responder: RTL and testbench
===================================

Name: dma_io_responder

Overview:
- Peripheral-side endpoint of the 8237A DMA handshake: raises DREQ, answers DACK, and sources or sinks one byte per IOR/IOW strobe.
- Honours EOP from the controller and can drive EOP itself after a programmed byte count.
- Sits in the testbench/system as the I/O device opposite the DMA control interface, buffering bytes between a local valid/ready stream and the DMA data bus.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX (device-to-memory) and RX (memory-to-device) byte FIFOs; power of two, >=2.
- DREQ_ACTIVE_HIGH, 1, DREQ polarity; 1 = active high.
- DACK_ACTIVE_HIGH, 0, DACK polarity; 0 = active low.

Ports:
- CLK  in  1  clock; all inputs sampled on rising edge, no synchronizers.
- RESET  in  1  synchronous, active-high reset.
- xfer_en  in  1  enables requesting.
- xfer_dir  in  1  0 = device-to-memory (IOR reads device); 1 = memory-to-device (IOW writes device).
- count_limit  in  16  bytes before self-termination; 0 = unlimited.
- src_data  in  8  local byte into TX FIFO.
- src_valid  in  1  local push request.
- src_ready  out  1  TX FIFO not full.
- snk_data  out  8  RX FIFO head.
- snk_valid  out  1  RX FIFO not empty.
- snk_ready  in  1  local pop.
- DREQ  out  1  DMA request, polarity per DREQ_ACTIVE_HIGH.
- DACK  in  1  DMA acknowledge, polarity per DACK_ACTIVE_HIGH.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N_IN  in  1  end of process from controller, active low.
- EOP_N_OUT  out  1  end-of-process drive request, active low.
- db_in  in  8  DMA data bus in.
- db_out  out  8  DMA data bus out.
- db_oe  out  1  db_out enable.
- xfer_cnt  out  16  bytes transferred since xfer_en rise.
- term_done  out  1  sticky; transfer terminated.
- err  out  1  sticky protocol/flow error.

Behaviour:
- Reset state: DREQ inactive level; EOP_N_OUT=1; db_oe=0; db_out=0; xfer_cnt=0; term_done=0; err=0; both FIFOs empty; FSM IDLE. Reset mid-strobe aborts with no push/pop.
- ack = DACK at active level. A strobe is valid only while ack. strobe = IOR_N low when xfer_dir=0, IOW_N low when xfer_dir=1.
- have_work = (xfer_dir=0 and TX non-empty) or (xfer_dir=1 and RX not full).
- FSM IDLE:
  - -> REQ when xfer_en & have_work & !term_done.
- FSM REQ:
  - DREQ active, registered, so it appears 1 cycle after entry.
  - -> XFER on first sampled valid strobe.
  - -> IDLE if xfer_en drops.
- FSM XFER:
  - Read (dir 0): db_oe=1 and db_out=TX head from the cycle after IOR_N is sampled low until the cycle after it is sampled high. On the IOR_N rising edge (prev low, now high), pop TX and increment xfer_cnt.
  - Write (dir 1): db_in is registered every cycle IOW_N is low; on the IOW_N rising edge, push the last registered byte into RX and increment xfer_cnt.
  - -> RECOVER on strobe release.
- FSM RECOVER (1 cycle):
  - -> TERM if termination is pending.
  - else -> REQ if xfer_en & have_work (DREQ stays active, demand style).
  - else -> IDLE (DREQ goes inactive in this cycle).
- FSM TERM:
  - DREQ inactive; term_done=1.
  - Leaves only when xfer_en=0, -> IDLE. This clears term_done and xfer_cnt; FIFOs are kept.
- Self-termination: when count_limit!=0 and xfer_cnt == count_limit-1, EOP_N_OUT=0 for the duration of that byte's strobe (XFER state), then termination is pending.
- EOP_N_IN sampled low while ack or in XFER: termination pending; the current byte still completes.
- xfer_cnt saturates at 0xFFFF.
- Local side:
  - src push when src_valid & src_ready.
  - snk pop when snk_valid & snk_ready.
  - A simultaneous local push and DMA pop (or DMA push and local pop) is legal, including at full/empty boundaries. The occupancy change is the net result.
- Error cases (all set err sticky; cleared only by RESET):
  - IOR_N and IOW_N both low while ack: no transfer.
  - Strobe for the wrong direction: no transfer.
  - IOR with TX empty: db_out=0xFF, no pop, no count.
  - IOW with RX full: byte dropped, no count.
- Strobes while DACK is inactive are ignored (no err).

Test Plan:
- Reset, xfer_dir=0, push 3 bytes 0xA1,0xA2,0xA3; DMA gives DACK low plus three IOR_N pulses -> db_out 0xA1,0xA2,0xA3 with db_oe during each; xfer_cnt=3; DREQ inactive after the 3rd pulse's RECOVER.
- xfer_dir=1, DMA gives 8 IOW_N pulses with db_in 0x10..0x17, snk_ready=0 -> RX full; DREQ inactive after the 8th; a 9th pulse sets err, data dropped; snk pops yield 0x10..0x17.
- count_limit=2, dir 0, 4 bytes queued -> EOP_N_OUT low during the 2nd IOR strobe only; term_done=1; DREQ stays inactive although TX holds 2; xfer_en 0->1 reissues DREQ.
- EOP_N_IN pulsed low during the 1st IOW strobe -> that byte is pushed, xfer_cnt=1, then TERM.
- RESET asserted while IOR_N is low with db_oe=1 -> next cycle db_oe=0, DREQ inactive, FIFOs empty, err=0.
- IOR_N and IOW_N low together under DACK, and IOR with empty TX -> err=1, db_out=0xFF, xfer_cnt unchanged.

Source files
------------

// File: rtl/dma_io_responder.sv
// rtl/dma_io_responder.sv - 8237A-style DMA peripheral endpoint with TX/RX byte FIFOs
module dma_io_responder #(
  parameter int FIFO_DEPTH       = 8,
  parameter bit DREQ_ACTIVE_HIGH = 1'b1,
  parameter bit DACK_ACTIVE_HIGH = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        xfer_en,
  input  logic        xfer_dir,
  input  logic [15:0] count_limit,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic        DREQ,
  input  logic        DACK,
  input  logic        IOR_N,
  input  logic        IOW_N,
  input  logic        EOP_N_IN,
  output logic        EOP_N_OUT,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic [15:0] xfer_cnt,
  output logic        term_done,
  output logic        err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, REQ, XFER, RECOVER, TERM} state_t;
  state_t state, state_next;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  logic ack, ior, iow, strobe, wrong, have_work, start, strobe_rel, do_xfer;
  logic limit_hit, drive, err_set, dreq_now, dreq_next;
  logic term_pend, xfer_bad, dreq_q, xfer_en_q;
  logic [7:0] wr_byte;

  assign ack       = (DACK == DACK_ACTIVE_HIGH);
  assign ior       = !IOR_N;
  assign iow       = !IOW_N;
  assign strobe    = xfer_dir ? iow : ior;
  assign wrong     = xfer_dir ? ior : iow;

  // Occupancy counters carry one extra bit so full is simply the MSB.
  assign tx_empty  = (tx_cnt == '0);
  assign tx_full   = tx_cnt[AW];
  assign rx_empty  = (rx_cnt == '0);
  assign rx_full   = rx_cnt[AW];

  assign have_work  = xfer_dir ? !rx_full : !tx_empty;
  assign start      = ack && strobe && !wrong && have_work;
  assign strobe_rel = (state == XFER) && !strobe;
  assign do_xfer    = strobe_rel && !xfer_bad && !(ack && wrong) && (xfer_dir ? !rx_full : !tx_empty);
  assign limit_hit  = (count_limit != 16'd0) && (xfer_cnt == count_limit - 16'd1);
  assign drive      = !xfer_dir && ior && !iow && (ack || state == XFER);
  assign err_set    = ack && (wrong || (!xfer_dir && ior && tx_empty) || (xfer_dir && iow && rx_full));

  assign src_ready = !tx_full;
  assign snk_valid = !rx_empty;
  assign snk_data  = rx_mem[rx_rp];
  assign tx_push   = src_valid && src_ready;
  assign rx_pop    = snk_valid && snk_ready;
  assign tx_pop    = do_xfer && !xfer_dir;
  assign rx_push   = do_xfer && xfer_dir;

  assign DREQ      = DREQ_ACTIVE_HIGH ? dreq_q : !dreq_q;
  assign EOP_N_OUT = !((state == XFER) && limit_hit);

  assign dreq_now  = state inside {REQ, XFER, RECOVER};
  assign dreq_next = state_next inside {REQ, XFER, RECOVER};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (term_pend) state_next = TERM;
               else if (xfer_en && have_work && !term_done) state_next = REQ;
      REQ:     if (start) state_next = XFER;
               else if (!xfer_en) state_next = IDLE;
      XFER:    if (!strobe) state_next = RECOVER;
      RECOVER: if (term_pend) state_next = TERM;
               else if (xfer_en && have_work) state_next = REQ;
               else state_next = IDLE;
      TERM:    if (!xfer_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= src_data;
    if (rx_push) rx_mem[rx_wp] <= wr_byte;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      dreq_q    <= 1'b0;
      db_oe     <= 1'b0;
      db_out    <= 8'h00;
      xfer_cnt  <= 16'd0;
      term_done <= 1'b0;
      err       <= 1'b0;
      term_pend <= 1'b0;
      xfer_bad  <= 1'b0;
      xfer_en_q <= 1'b0;
      wr_byte   <= 8'h00;
    end else begin
      state     <= state_next;
      xfer_en_q <= xfer_en;
      dreq_q    <= dreq_now && dreq_next;
      db_oe     <= drive;
      db_out    <= drive ? (tx_empty ? 8'hFF : tx_mem[tx_rp]) : 8'h00;
      term_done <= (state_next == TERM);
      if (err_set) err <= 1'b1;
      if (iow) wr_byte <= db_in;
      // A protocol violation inside a strobe spoils that byte only.
      if (state == XFER) begin
        if (ack && wrong) xfer_bad <= 1'b1;
      end else begin
        xfer_bad <= 1'b0;
      end
      if ((do_xfer && limit_hit) || (!EOP_N_IN && (ack || state == XFER))) term_pend <= 1'b1;
      if (state == TERM && !xfer_en) term_pend <= 1'b0;
      if ((state == TERM && !xfer_en) || (xfer_en && !xfer_en_q)) xfer_cnt <= 16'd0;
      else if (do_xfer && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dma_io_responder.sv
// tb/tb_dma_io_responder.sv - directed bench with a queue-based reference model
module tb_dma_io_responder;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET, xfer_en, xfer_dir, src_valid, snk_ready;
  logic        DACK, IOR_N, IOW_N, EOP_N_IN;
  logic [15:0] count_limit;
  logic [7:0]  src_data, db_in;
  logic        src_ready, snk_valid, DREQ, EOP_N_OUT, db_oe, term_done, err;
  logic [7:0]  snk_data, db_out;
  logic [15:0] xfer_cnt;

  always #5 CLK = ~CLK;

  dma_io_responder #(.FIFO_DEPTH(DEPTH), .DREQ_ACTIVE_HIGH(1'b1), .DACK_ACTIVE_HIGH(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .xfer_en(xfer_en), .xfer_dir(xfer_dir), .count_limit(count_limit),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N_IN(EOP_N_IN), .EOP_N_OUT(EOP_N_OUT), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .xfer_cnt(xfer_cnt), .term_done(term_done), .err(err)
  );

  int checks = 0;
  int failures = 0;
  logic        chk_en = 1'b0;
  logic [7:0]  q_tx[$];
  logic [7:0]  q_rx[$];
  logic [15:0] exp_cnt;
  logic        exp_err, exp_term, exp_oe, exp_eop;
  logic [7:0]  exp_dout;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, 16'(act), 16'(req));
  endtask
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    chk(name, 16'(act), 16'(req));
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk1("src_ready", src_ready, q_tx.size() < DEPTH);
      chk1("snk_valid", snk_valid, q_rx.size() > 0);
      if (q_rx.size() > 0) chk8("snk_data", snk_data, q_rx[0]);
      chk("xfer_cnt", xfer_cnt, exp_cnt);
      chk1("err", err, exp_err);
      chk1("term_done", term_done, exp_term);
      chk1("db_oe", db_oe, exp_oe);
      chk8("db_out", db_out, exp_dout);
      chk1("eop_n_out", EOP_N_OUT, exp_eop);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    q_tx.delete(); q_rx.delete();
    exp_cnt = 16'd0; exp_err = 1'b0; exp_term = 1'b0;
    exp_oe = 1'b0; exp_dout = 8'h00; exp_eop = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    logic rdy;
    rdy = q_tx.size() < DEPTH;
    src_data = b; src_valid = 1'b1;
    step();
    if (rdy) q_tx.push_back(b);
    src_valid = 1'b0;
  endtask

  task automatic snk_pop(input logic [7:0] lit);
    snk_ready = 1'b1;
    chk8("snk_lit", snk_data, lit);
    step();
    if (q_rx.size() > 0) void'(q_rx.pop_front());
    snk_ready = 1'b0;
  endtask

  task automatic wait_dreq();
    int n;
    n = 0;
    while (DREQ !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk1("dreq_wait", DREQ, 1'b1);
  endtask

  task automatic ior_pulse(input logic [7:0] lit, input int w);
    logic hit;
    hit = (count_limit != 16'd0) && (exp_cnt == count_limit - 16'd1);
    IOR_N = 1'b0;
    step();
    exp_oe = 1'b1; exp_dout = (q_tx.size() > 0) ? q_tx[0] : 8'hFF; exp_eop = !hit;
    chk8("db_out_lit", db_out, lit);
    repeat (w - 1) step();
    IOR_N = 1'b1;
    step();
    exp_oe = 1'b0; exp_dout = 8'h00; exp_eop = 1'b1;
    if (q_tx.size() > 0) begin
      void'(q_tx.pop_front());
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    step();
    if (hit) exp_term = 1'b1;
    chk1("dreq_after_rd", DREQ, !hit && xfer_en && q_tx.size() > 0);
  endtask

  task automatic iow_pulse(input logic [7:0] b, input logic eop);
    logic hit;
    hit = (count_limit != 16'd0) && (exp_cnt == count_limit - 16'd1);
    db_in = b; IOW_N = 1'b0; EOP_N_IN = !eop;
    step();
    exp_eop = !hit; EOP_N_IN = 1'b1;
    step();
    IOW_N = 1'b1;
    step();
    exp_eop = 1'b1;
    if (q_rx.size() < DEPTH) begin
      q_rx.push_back(b);
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    step();
    if (hit || eop) exp_term = 1'b1;
    chk1("dreq_after_wr", DREQ, !(hit || eop) && xfer_en && q_rx.size() < DEPTH);
  endtask

  initial begin
    RESET = 1'b1; xfer_en = 1'b0; xfer_dir = 1'b0; count_limit = 16'd0;
    src_data = 8'h00; src_valid = 1'b0; snk_ready = 1'b0;
    DACK = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N_IN = 1'b1; db_in = 8'h00;
    model_clear();
    step(); step();
    RESET = 1'b0;
    chk_en = 1'b1;
    chk1("rst_dreq", DREQ, 1'b0);
    chk1("rst_eop", EOP_N_OUT, 1'b1);
    chk1("rst_oe", db_oe, 1'b0);
    chk("rst_cnt", xfer_cnt, 16'd0);
    chk1("rst_err", err, 1'b0);

    // device-to-memory, three bytes
    push(8'hA1); push(8'hA2); push(8'hA3);
    xfer_en = 1'b1; step(); exp_cnt = 16'd0;
    DACK = 1'b0;
    wait_dreq(); ior_pulse(8'hA1, 2);
    wait_dreq(); ior_pulse(8'hA2, 3);
    wait_dreq(); ior_pulse(8'hA3, 2);
    chk("t1_cnt", xfer_cnt, 16'd3);
    chk1("t1_dreq_off", DREQ, 1'b0);
    DACK = 1'b1; xfer_en = 1'b0; step();

    // memory-to-device until RX full, then an overflowing write
    xfer_dir = 1'b1; xfer_en = 1'b1; step(); exp_cnt = 16'd0;
    DACK = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_dreq();
      iow_pulse(8'(8'h10 + i), 1'b0);
    end
    chk("t2_cnt8", xfer_cnt, 16'd8);
    chk1("t2_dreq_off", DREQ, 1'b0);
    db_in = 8'h99; IOW_N = 1'b0; step(); exp_err = 1'b1;
    IOW_N = 1'b1; step();
    chk1("t2_err", err, 1'b1);
    chk("t2_cnt_hold", xfer_cnt, 16'd8);
    DACK = 1'b1; xfer_en = 1'b0; step();
    for (int i = 0; i < 8; i++) snk_pop(8'(8'h10 + i));

    // self-termination after two bytes
    xfer_dir = 1'b0; count_limit = 16'd2;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    xfer_en = 1'b1; step(); exp_cnt = 16'd0;
    DACK = 1'b0;
    wait_dreq(); ior_pulse(8'hB1, 2);
    chk1("t3_eop_idle", EOP_N_OUT, 1'b1);
    wait_dreq(); ior_pulse(8'hB2, 3);
    chk1("t3_term", term_done, 1'b1);
    repeat (3) step();
    chk1("t3_dreq_hold", DREQ, 1'b0);
    DACK = 1'b1; xfer_en = 1'b0; step(); exp_term = 1'b0; exp_cnt = 16'd0;
    xfer_en = 1'b1; step();
    chk1("t3_dreq_entry", DREQ, 1'b0);
    step();
    chk1("t3_dreq_reissue", DREQ, 1'b1);
    xfer_en = 1'b0; step(); step();

    // controller EOP during the first write
    count_limit = 16'd0; xfer_dir = 1'b1; xfer_en = 1'b1; step(); exp_cnt = 16'd0;
    DACK = 1'b0;
    wait_dreq(); iow_pulse(8'h5A, 1'b1);
    chk("t4_cnt", xfer_cnt, 16'd1);
    chk1("t4_term", term_done, 1'b1);
    snk_pop(8'h5A);
    DACK = 1'b1; xfer_en = 1'b0; step(); exp_term = 1'b0; exp_cnt = 16'd0;

    // reset in the middle of a read strobe
    xfer_dir = 1'b0; xfer_en = 1'b1; step(); exp_cnt = 16'd0;
    DACK = 1'b0;
    wait_dreq();
    IOR_N = 1'b0; step();
    exp_oe = 1'b1; exp_dout = q_tx[0];
    chk8("t5_dout", db_out, 8'hB3);
    RESET = 1'b1; step(); model_clear();
    chk1("t5_oe", db_oe, 1'b0);
    chk1("t5_dreq", DREQ, 1'b0);
    chk1("t5_err", err, 1'b0);
    RESET = 1'b0; IOR_N = 1'b1; step();

    // strobes without DACK are ignored
    DACK = 1'b1; IOR_N = 1'b0; IOW_N = 1'b0; step(); step();
    IOR_N = 1'b1; IOW_N = 1'b1; step();
    chk1("t6_ignored", err, 1'b0);

    // both strobes under DACK, then a read from an empty TX
    DACK = 1'b0; IOR_N = 1'b0; IOW_N = 1'b0; step(); exp_err = 1'b1;
    chk1("t6_both_err", err, 1'b1);
    chk1("t6_both_oe", db_oe, 1'b0);
    IOR_N = 1'b1; IOW_N = 1'b1; step();
    IOR_N = 1'b0; step(); exp_oe = 1'b1; exp_dout = 8'hFF;
    chk8("t6_ff", db_out, 8'hFF);
    step();
    IOR_N = 1'b1; step(); exp_oe = 1'b0; exp_dout = 8'h00;
    chk("t6_cnt", xfer_cnt, 16'd0);
    DACK = 1'b1; step(); step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
